adc128s_fc: RTL and testbench
=============================

Name: adc128s_fc

Overview:
- Behavioural/synthesizable model of an 8-channel, 12-bit SPI A2D converter (ADC128S-style) used in the Segway bench.
- Acts as SPI slave to the Segway A2D interface master.
- Supplies load-cell, steering-pot and battery readings, taken from 12-bit stimulus inputs, as conversion results.
- Uses a pipelined protocol: the channel requested in one transaction is returned in the next.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all logic is synchronous to its rising edge
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  SPI slave select, active low, frames one 16-bit transaction
- SCLK  input  1  SPI serial clock from master, idle low (mode 0)
- MOSI  input  1  SPI master-out data
- MISO  output  1  SPI master-in data
- ld_cell_lft  input  12  value returned for channel 0
- ld_cell_rght  input  12  value returned for channel 4
- steerPot  input  12  value returned for channel 5
- batt  input  12  value returned for channel 6

Behaviour:
- Input synchronisation: SS_n, SCLK and MOSI are double-flopped on clk.
  - SCLK rise/fall and SS_n fall/rise edges are detected from the synchronised signals.
  - The master guarantees SCLK high and low phases of at least 4 clk each.
- Transaction format: 16 SCLK cycles per SS_n-low frame, MSB first in both directions.
- MOSI command word: bits[13:11] = channel address (0-7). All other bits are ignored.
- MISO response word: {4'b0000, result[11:0]}.
- On the SS_n falling edge: load the 16-bit tx shift register with {4'b0, result}. MISO immediately shows bit 15.
- On each SCLK rising edge (SS_n low): shift the synchronised MOSI into the 16-bit rx shift register LSB.
- On each SCLK falling edge (SS_n low): shift the tx register left by one; MISO = tx[15].
- On the SS_n rising edge:
  - chnl <= rx[13:11].
  - result <= value of the newly selected channel: 0 -> ld_cell_lft, 4 -> ld_cell_rght, 5 -> steerPot, 6 -> batt; 1, 2, 3, 7 -> 12'h000.
  - The inputs are sampled at this instant.
- Latency: the data for the channel sent in transaction N appears on MISO during transaction N+1.
- Aborted frame (SS_n rises before 16 SCLKs): still latch chnl from the current rx[13:11] and sample result. No error flag.
- More than 16 SCLKs in a frame: keep shifting. The last 16 bits received define the command; the tx register shifts in 0s.
- MISO is driven 0 while SS_n is high. It is never tri-stated.
- SCLK edges while SS_n is high are ignored.
- Reset: rx = 0, tx = 0, chnl = 0, result = 12'h000, MISO = 0, synchronisers set to SS_n=1, SCLK=0. Reset mid-frame abandons the frame.
  - The first transaction after reset returns 12'h000.
- Stimulus inputs may change at any time. Only the value at the SS_n rise is used.

Test Plan:
- Reset then a single frame with MOSI = 16'h0000 -> MISO word = 16'h0000.
- ld_cell_lft = 12'h400; frame 1 sends chnl 0 (16'h0000), frame 2 sends any word -> frame 2 MISO = 16'h0400.
- ld_cell_rght = 12'h3A5, steerPot = 12'h800, batt = 12'hC00; send chnl 4, 5, 6, then a dummy frame -> MISO words 16'h03A5, 16'h0800, 16'h0C00 in frames 2-4.
- Request chnl 2 (16'h1000), then a dummy frame -> 16'h0000. Request chnl 7 -> 16'h0000.
- Change batt from 12'hC00 to 12'h9AB after the chnl-6 request frame ends -> the next frame still returns 16'h0C00.
- Abort a frame after 8 SCLKs, then run a full chnl-0 request and readback -> correct 12'h400 returned; MISO = 0 whenever SS_n is high.

Source files
------------

// File: rtl/adc128s_fc.sv
// SPI-slave model of an 8-channel 12-bit ADC: the channel requested in one frame is returned in the next.
// SPI pins are double-flopped on clk; MISO is registered and held low while SS_n is high.
module adc128s_fc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] ld_cell_lft,
  input  logic [11:0] ld_cell_rght,
  input  logic [11:0] steerPot,
  input  logic [11:0] batt
);

  logic [2:0]  ss_sr;
  logic [2:0]  sclk_sr;
  logic [1:0]  mosi_sr;
  logic [15:0] rx;
  logic [15:0] tx;
  logic [2:0]  chnl;
  logic [11:0] result;
  logic        sample;
  logic        miso_q;

  logic ss_sync, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_sync;
  logic [15:0] tx_load;
  logic [11:0] chnl_val;

  // Bit [1] of each shifter is the synchronised level; bit [2] is its previous value for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sr   <= 3'b111;
      sclk_sr <= 3'b000;
      mosi_sr <= 2'b00;
    end else begin
      ss_sr   <= {ss_sr[1:0], SS_n};
      sclk_sr <= {sclk_sr[1:0], SCLK};
      mosi_sr <= {mosi_sr[0], MOSI};
    end
  end

  assign ss_sync   = ss_sr[1];
  assign ss_fall   = ss_sr[2] & ~ss_sr[1];
  assign ss_rise   = ~ss_sr[2] & ss_sr[1];
  assign sclk_rise = ~sclk_sr[2] & sclk_sr[1];
  assign sclk_fall = sclk_sr[2] & ~sclk_sr[1];
  assign mosi_sync = mosi_sr[1];
  assign tx_load   = {4'h0, result};

  always_comb begin
    chnl_val = 12'h000;
    case (chnl)
      3'd0:    chnl_val = ld_cell_lft;
      3'd4:    chnl_val = ld_cell_rght;
      3'd5:    chnl_val = steerPot;
      3'd6:    chnl_val = batt;
      default: chnl_val = 12'h000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx     <= 16'h0000;
      tx     <= 16'h0000;
      chnl   <= 3'd0;
      result <= 12'h000;
      sample <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      sample <= 1'b0;
      // The channel is latched on the SS_n rise; the stimulus is sampled on the following clk.
      if (sample)
        result <= chnl_val;
      if (ss_fall) begin
        tx     <= tx_load;
        miso_q <= tx_load[15];
      end else if (ss_rise) begin
        chnl   <= rx[13:11];
        sample <= 1'b1;
        miso_q <= 1'b0;
      end else if (!ss_sync) begin
        if (sclk_rise)
          rx <= {rx[14:0], mosi_sync};
        if (sclk_fall) begin
          tx     <= {tx[14:0], 1'b0};
          miso_q <= tx[14];
        end
      end
    end
  end

  assign MISO = miso_q;

endmodule

// File: tb/tb_adc128s_fc.sv
// Randomised bench for adc128s_fc against a frame-level model of the pipelined channel readback.
module tb_adc128s_fc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [11:0] ld_cell_lft, ld_cell_rght, steerPot, batt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: last 16 command bits received and the result queued for the next frame.
  logic [15:0] rx_m;
  logic [11:0] result_m;

  adc128s_fc dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ld_cell_lft(ld_cell_lft), .ld_cell_rght(ld_cell_rght), .steerPot(steerPot), .batt(batt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [11:0] chan_value(input logic [2:0] ch);
    case (ch)
      3'd0:    return ld_cell_lft;
      3'd4:    return ld_cell_rght;
      3'd5:    return steerPot;
      3'd6:    return batt;
      default: return 12'h000;
    endcase
  endfunction

  // Sends the low n bits of stream MSB first; compares every MISO bit sampled at SCLK rises.
  task automatic run_frame(input string tag, input logic [31:0] stream, input int n);
    logic [31:0] got, exp;
    logic [15:0] word;
    word = {4'h0, result_m};
    got = '0;
    exp = '0;
    SS_n = 1'b0;
    wclk(6);
    for (int k = 0; k < n; k++) begin
      MOSI = stream[n-1-k];
      wclk(8);
      SCLK = 1'b1;
      got  = {got[30:0], MISO};
      exp  = {exp[30:0], (k < 16) ? word[15-k] : 1'b0};
      rx_m = {rx_m[14:0], MOSI};
      wclk(8);
      SCLK = 1'b0;
    end
    wclk(8);
    SS_n = 1'b1;
    result_m = chan_value(rx_m[13:11]);
    wclk(8);
    check(tag, got, exp);
    check({tag, "_idle"}, {31'd0, MISO}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    ld_cell_lft = 12'h400; ld_cell_rght = 12'h3A5; steerPot = 12'h800; batt = 12'hC00;
    rx_m = '0; result_m = '0;
    wclk(5);
    check("reset_miso", {31'd0, MISO}, 32'd0);
    rst_n = 1'b1;
    wclk(4);

    run_frame("first_after_reset", 32'h0000, 16);
    run_frame("req_ch4_ret_ch0",   32'h2000, 16);
    run_frame("req_ch5_ret_ch4",   32'h2800, 16);
    run_frame("req_ch6_ret_ch5",   32'h3000, 16);
    batt = 12'h9AB;
    run_frame("req_ch2_ret_ch6",   32'h1000, 16);
    run_frame("req_ch7_ret_ch2",   32'h3800, 16);
    run_frame("req_ch0_ret_ch7",   32'hC7FF, 16);
    run_frame("abort_8",           32'h00A5, 8);
    run_frame("after_abort",       32'h0000, 16);
    run_frame("readback_ch0",      32'h0000, 16);
    run_frame("long_frame",        32'h00FF_3000, 24);
    run_frame("after_long",        32'h0000, 16);

    for (int i = 0; i < 40; i++) begin
      int sel, n;
      sel = $urandom_range(0, 9);
      n = (sel < 7) ? 16 : (sel < 8) ? $urandom_range(17, 24) : $urandom_range(3, 15);
      ld_cell_lft  = 12'($urandom);
      ld_cell_rght = 12'($urandom);
      steerPot     = 12'($urandom);
      batt         = 12'($urandom);
      run_frame("random", $urandom, n);
    end

    // Reset in the middle of a frame abandons it; the next readback is zero.
    SS_n = 1'b0;
    wclk(6);
    for (int k = 0; k < 5; k++) begin
      MOSI = 1'b1; wclk(8); SCLK = 1'b1; wclk(8); SCLK = 1'b0;
    end
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0;
    wclk(3);
    check("midframe_reset_miso", {31'd0, MISO}, 32'd0);
    rst_n = 1'b1;
    rx_m = '0; result_m = '0;
    wclk(4);
    run_frame("post_reset_zero", 32'h2000, 16);
    run_frame("post_reset_ch4",  32'h0000, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
